// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline stage boundary with a valid/ready handshake.
// Carries an opaque payload plus control bits. Control bits are forced to zero
// whenever the stage holds no entry. Payload is zeroed as well when CLEAR_DATA=1.
// A saturating counter records the cycles spent back-pressured.
// Optional macro PIPE_STAGE_SKID_EN selects a 2-entry skid buffer. With it,
// in_ready comes from flops only. Without it, the stage is a single register
// whose in_ready depends combinationally on out_ready.
`timescale 1ns/1ps

module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Payload value presented by an empty slot: zero, or the stale value when clearing is off.
  function automatic logic [DATA_W-1:0] bubble_data(input logic [DATA_W-1:0] held);
    return (CLEAR_DATA != 0) ? '0 : held;
  endfunction

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic              accept;
  logic              consume;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // The skid slot is occupied exactly in ST_TWO, so in_ready is a pure flop decode.
  assign in_ready  = (state_q != ST_TWO) && !flush;
  assign out_valid = (state_q != ST_EMPTY);

  // State, output and skid registers; async reset empties both slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Next state and slot contents; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      out_data_d  = bubble_data(out_data_q);
      out_ctrl_d  = '0;
      skid_data_d = bubble_data(skid_data_q);
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_data_d = in_data;
            out_ctrl_d = in_ctrl;
          end else if (accept) begin
            // Downstream stalled this cycle: park the newcomer behind the head.
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (consume) begin
            state_d    = ST_EMPTY;
            out_data_d = bubble_data(out_data_q);
            out_ctrl_d = '0;
          end
        end
        ST_TWO: begin
          if (consume) begin
            state_d     = ST_ONE;
            out_data_d  = skid_data_q;
            out_ctrl_d  = skid_ctrl_q;
            skid_data_d = bubble_data(skid_data_q);
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          out_data_d = bubble_data(out_data_q);
          out_ctrl_d = '0;
        end
      endcase
    end
  end

`else

  logic out_valid_q, out_valid_d;

  // Single register: a consume frees the slot in the same cycle it is refilled.
  assign in_ready  = !flush && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;

  // Output register; async reset leaves the stage empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
    end
  end

  // Load on accept, bubble on flush or on consume with nothing behind it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_data_d  = bubble_data(out_data_q);
      out_ctrl_d  = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_ctrl_d  = in_ctrl;
    end else if (consume) begin
      out_valid_d = 1'b0;
      out_data_d  = bubble_data(out_data_q);
      out_ctrl_d  = '0;
    end
  end

`endif

  // Back-pressure counter; flush does not touch it, only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Count every cycle an entry is held while downstream refuses it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a long random run checked
// against a queue holding the entries the stage should currently contain.
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
`timescale 1ns/1ps

module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [15:0] stall_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;
  logic [7:0]  out_ctrl4;
  logic [3:0]  stall_cnt4;

  ent_t        sb[$];
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  int          n_checks = 0;
  int          n_fail = 0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_ctrl(out_ctrl4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_in_ready();
    if (flush) return 1'b0;
    if (SKID) return (sb.size() < 2);
    return (sb.size() == 0) || out_ready;
  endfunction

  // Advance one clock: update the reference contents at the edge, return at the next negedge.
  task automatic tick(output bit acc);
    bit cons;
    acc  = exp_in_ready() && in_valid;
    cons = (sb.size() > 0) && out_ready;
    if (sb.size() > 0 && !out_ready) begin
      if (cnt16 != 16'hFFFF) cnt16 = cnt16 + 16'd1;
      if (cnt4 != 4'hF) cnt4 = cnt4 + 4'd1;
    end
    @(posedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (cons) void'(sb.pop_front());
      if (acc) sb.push_back('{d: in_data, c: in_ctrl});
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    sb.delete();
    cnt16 = '0;
    cnt4  = '0;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); cnt16 = '0; cnt4 = '0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (out_ctrl !== 8'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_midstream();
    bit acc;
    in_valid = 1'b1; in_data = 32'h12; in_ctrl = 8'hA5; out_ready = 1'b0;
    tick(acc);
    idle_inputs();
    tick(acc);
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_ctrl !== 8'hA5) begin n_fail++; $display("FAIL midstream_held: got v=%b c=%h want v=1 c=a5", out_valid, out_ctrl); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL midstream_cnt: got %0d want 1", stall_cnt); end
    // Reset asserted between edges must clear everything without a clock.
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_ctrl !== 8'h0) begin n_fail++; $display("FAIL async_rst_ctrl: got %h want 0", out_ctrl); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL async_rst_data: got %h want 0", out_data); end
    n_checks++; if (stall_cnt !== 16'h0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d want 0", stall_cnt); end
    rst = 1'b0;
    sb.delete(); cnt16 = '0; cnt4 = '0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_in_ready: got %b want 1", in_ready); end
    tick(acc);
  endtask

  task automatic test_stream();
    bit acc;
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) begin
        in_valid = 1'b1; in_data = 32'(i); in_ctrl = 8'(i) ^ 8'h5A;
      end else begin
        idle_inputs();
      end
      #1;
      if (i <= 8) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      end
      if (i == 1) begin
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_empty: got %b want 0", out_valid); end
      end else begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'(i - 1) || out_ctrl !== (8'(i - 1) ^ 8'h5A)) begin
          n_fail++; $display("FAIL stream_out[%0d]: got v=%b d=%h c=%h want v=1 d=%h", i, out_valid, out_data, out_ctrl, 32'(i - 1));
        end
      end
      tick(acc);
    end
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    bit acc;
    bit pending;
    pulse_reset();
    idle_inputs();
    in_valid = 1'b1; in_data = 32'h33; in_ctrl = 8'h11; out_ready = 1'b1;
    tick(acc);
    in_data = 32'h44; in_ctrl = 8'h22; out_ready = 1'b0;
    pending = 1'b1;
    for (int s = 0; s < 5; s++) begin
      in_valid = pending;
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=33", s, out_valid, out_data); end
      n_checks++;
      if (in_ready !== ((SKID && s == 0) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", s, in_ready, (SKID && s == 0));
      end
      tick(acc);
      if (acc) pending = 1'b0;
    end
    #1;
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
    n_checks++; if (pending !== !SKID) begin n_fail++; $display("FAIL bp_skid_accept: got pending=%b want %b", pending, !SKID); end
    out_ready = 1'b1; in_valid = pending;
    #1;
    n_checks++; if (out_data !== 32'h33 || out_ctrl !== 8'h11) begin n_fail++; $display("FAIL bp_release_first: got d=%h c=%h want d=33 c=11", out_data, out_ctrl); end
    tick(acc);
    idle_inputs();
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h44 || out_ctrl !== 8'h22) begin n_fail++; $display("FAIL bp_release_second: got v=%b d=%h c=%h want v=1 d=44 c=22", out_valid, out_data, out_ctrl); end
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_cnt_after: got %0d want 5", stall_cnt); end
    tick(acc);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    bit acc;
    in_valid = 1'b1; in_data = 32'h66; in_ctrl = 8'h3C; out_ready = 1'b0;
    tick(acc);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'hFF; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h66) begin n_fail++; $display("FAIL flush_pre: got v=%b d=%h want v=1 d=66", out_valid, out_data); end
    tick(acc);
    idle_inputs(); out_ready = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_checks++; if (out_ctrl !== 8'h0) begin n_fail++; $display("FAIL flush_ctrl: got %h want 0", out_ctrl); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL flush_data: got %h want 0", out_data); end
    n_checks++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL flush_cnt_kept: got %0d want 6", stall_cnt); end
    tick(acc);
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data === 32'h77) begin n_fail++; $display("FAIL flush_no_77: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_saturation();
    bit acc;
    pulse_reset();
    idle_inputs();
    in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h01; out_ready = 1'b1;
    tick(acc);
    idle_inputs(); out_ready = 1'b0;
    for (int s = 1; s <= 20; s++) begin
      tick(acc);
      if (s == 15) begin
        #1;
        n_checks++; if (stall_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat_reach: got %h want f", stall_cnt4); end
      end
    end
    #1;
    n_checks++; if (stall_cnt4 !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h want f", stall_cnt4); end
    n_checks++; if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_wide_cnt: got %0d want 20", stall_cnt); end
    n_checks++; if (out_data !== 32'h55 || out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_data_stable: got v=%b d=%h want v=1 d=55", out_valid, out_data); end
    out_ready = 1'b1;
    tick(acc);
  endtask

  task automatic test_random();
    bit          acc;
    bit          pending;
    bit          ev;
    logic [31:0] ed;
    logic [7:0]  ec;
    pulse_reset();
    idle_inputs();
    pending = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      flush     = ($urandom_range(0, 31) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      if (!pending) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = $urandom;
        in_ctrl  = 8'($urandom);
      end
      #1;
      ev = (sb.size() > 0);
      ed = ev ? sb[0].d : 32'h0;
      ec = ev ? sb[0].c : 8'h0;
      n_checks++; if (in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, in_ready, exp_in_ready()); end
      n_checks++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_out_valid@%0d: got %b want %b", n, out_valid, ev); end
      n_checks++; if (out_data !== ed || out_ctrl !== ec) begin n_fail++; $display("FAIL rnd_out@%0d: got d=%h c=%h want d=%h c=%h", n, out_data, out_ctrl, ed, ec); end
      n_checks++; if (!out_valid && out_ctrl !== 8'h0) begin n_fail++; $display("FAIL rnd_invariant@%0d: got c=%h want 0", n, out_ctrl); end
      n_checks++; if (stall_cnt !== cnt16) begin n_fail++; $display("FAIL rnd_stall_cnt@%0d: got %0d want %0d", n, stall_cnt, cnt16); end
      n_checks++;
      if (out_valid4 !== ev || out_data4 !== ed || out_ctrl4 !== ec || stall_cnt4 !== cnt4 || in_ready4 !== exp_in_ready()) begin
        n_fail++; $display("FAIL rnd_cnt4_inst@%0d: got v=%b d=%h c=%h cnt=%h want v=%b d=%h c=%h cnt=%h", n, out_valid4, out_data4, out_ctrl4, stall_cnt4, ev, ed, ec, cnt4);
      end
      tick(acc);
      pending = in_valid && !acc && !flush;
    end
    idle_inputs(); out_ready = 1'b1;
    repeat (3) tick(acc);
    #1;
    n_checks++; if (out_valid !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got v=%b want 0 (ref entries %0d)", out_valid, sb.size()); end
  endtask

  initial begin
    cnt16 = '0;
    cnt4  = '0;
    test_reset();
    test_reset_midstream();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
